// File: rtl/frame_sequencer.sv
// Per-frame scheduler: divides clk into frame ticks, applies a frame-skip ratio,
// and runs one erase -> update -> draw handshake sequence per scheduled frame.
module frame_sequencer #(
   parameter int unsigned CYCLES_PER_FRAME = 833333,
   parameter int unsigned CNT_W            = 20,
   parameter int unsigned SKIP_W           = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              run,
   input  logic [SKIP_W-1:0] skip,
   input  logic              erase_done,
   input  logic              draw_done,
   output logic              frame_tick,
   output logic              erase_start,
   output logic              update_en,
   output logic              draw_start,
   output logic              busy,
   output logic [15:0]       frame_num,
   output logic [7:0]        overrun
);

   localparam int unsigned FRAME_W = 16;
   localparam int unsigned OVR_W   = 8;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CYCLES_PER_FRAME - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ERASE  = 2'd1,
      S_UPDATE = 2'd2,
      S_DRAW   = 2'd3
   } state_e;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
   state_e             state_q, state_d;
   logic               first_q, first_d;
   logic               erase_start_q, erase_start_d;
   logic               update_en_q, update_en_d;
   logic               draw_start_q, draw_start_d;
   logic [FRAME_W-1:0] frame_num_q, frame_num_d;
   logic [OVR_W-1:0]   overrun_q, overrun_d;
   logic               tick_c;
   logic               trigger_c;
   logic               seq_done_c;
   logic               overrun_inc_c;

   // Frame period divider and skip-ratio counter
   always_comb begin
      cnt_d      = cnt_q;
      skip_cnt_d = skip_cnt_q;
      tick_c     = run && (cnt_q == '0);
      trigger_c  = 1'b0;
      if (run) begin
         cnt_d = (cnt_q == '0) ? CNT_RELOAD : cnt_q - CNT_W'(1);
      end
      if (tick_c) begin
         if (skip_cnt_q == '0) begin
            skip_cnt_d = skip;
            trigger_c  = 1'b1;
         end else begin
            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
         end
      end
   end

   // Sequence controller; first_q marks the entry cycle of each state, during
   // which the done inputs are not yet looked at.
   always_comb begin
      state_d    = state_q;
      seq_done_c = 1'b0;
      unique case (state_q)
         S_IDLE:   if (trigger_c) state_d = S_ERASE;
         S_ERASE:  if (!first_q && erase_done) state_d = S_UPDATE;
         S_UPDATE: state_d = S_DRAW;
         S_DRAW: begin
            if (!first_q && draw_done) begin
               state_d    = S_IDLE;
               seq_done_c = 1'b1;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      first_d       = (state_d != state_q);
      erase_start_d = first_d && (state_d == S_ERASE);
      update_en_d   = (state_d == S_UPDATE);
      draw_start_d  = first_d && (state_d == S_DRAW);
   end

   // Statistics: completed sequences wrap, dropped triggers saturate
   always_comb begin
      overrun_inc_c = trigger_c && (state_q != S_IDLE) && (overrun_q != '1);
      frame_num_d   = frame_num_q + FRAME_W'(1);
      overrun_d     = overrun_q + OVR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q         <= CNT_RELOAD;
         skip_cnt_q    <= '0;
         state_q       <= S_IDLE;
         first_q       <= 1'b0;
         erase_start_q <= 1'b0;
         update_en_q   <= 1'b0;
         draw_start_q  <= 1'b0;
         frame_num_q   <= '0;
         overrun_q     <= '0;
      end else begin
         cnt_q         <= cnt_d;
         skip_cnt_q    <= skip_cnt_d;
         state_q       <= state_d;
         first_q       <= first_d;
         erase_start_q <= erase_start_d;
         update_en_q   <= update_en_d;
         draw_start_q  <= draw_start_d;
         if (seq_done_c)    frame_num_q <= frame_num_d;
         if (overrun_inc_c) overrun_q   <= overrun_d;
      end
   end

   assign frame_tick  = tick_c;
   assign erase_start = erase_start_q;
   assign update_en   = update_en_q;
   assign draw_start  = draw_start_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_num   = frame_num_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a 10-cycle frame period.
module tb_frame_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        run = 1'b1;
   logic [3:0]  skip = 4'd0;
   logic        erase_done = 1'b1;
   logic        draw_done = 1'b1;
   logic        frame_tick;
   logic        erase_start;
   logic        update_en;
   logic        draw_start;
   logic        busy;
   logic [15:0] frame_num;
   logic [7:0]  overrun;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   frame_sequencer #(
      .CYCLES_PER_FRAME(10),
      .CNT_W           (4),
      .SKIP_W          (4)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .run        (run),
      .skip       (skip),
      .erase_done (erase_done),
      .draw_done  (draw_done),
      .frame_tick (frame_tick),
      .erase_start(erase_start),
      .update_en  (update_en),
      .draw_start (draw_start),
      .busy       (busy),
      .frame_num  (frame_num),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Cycle 0 is the first cycle after the reset edge
   task automatic do_reset();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      cyc = 0;
   endtask

   initial begin
      // Basic sequence, skip=0, dones tied high
      run = 1'b1; skip = 4'd0; erase_done = 1'b1; draw_done = 1'b1;
      do_reset();
      chk("rst_tick", 32'(frame_tick), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame", 32'(frame_num), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_pulses", 32'({erase_start, update_en, draw_start}), 0);
      chk("rst_cnt", 32'(dut.cnt_q), 9);
      go_to(8);  chk("tick8", 32'(frame_tick), 0);
      go_to(9);  chk("tick9", 32'(frame_tick), 1);
                 chk("busy9", 32'(busy), 0);
      go_to(10); chk("erase10", 32'(erase_start), 1);
                 chk("busy10", 32'(busy), 1);
      go_to(11); chk("pulses11", 32'({erase_start, update_en, draw_start}), 0);
      go_to(12); chk("upd12", 32'({erase_start, update_en, draw_start}), 3'b010);
      go_to(13); chk("draw13", 32'({erase_start, update_en, draw_start}), 3'b001);
      go_to(14); chk("busy14", 32'(busy), 1);
                 chk("frame14", 32'(frame_num), 0);
      go_to(15); chk("busy15", 32'(busy), 0);
                 chk("frame15", 32'(frame_num), 1);
      go_to(19); chk("tick19", 32'(frame_tick), 1);
      go_to(20); chk("erase20", 32'(erase_start), 1);
      go_to(25); chk("frame25", 32'(frame_num), 2);
      go_to(29); chk("tick29", 32'(frame_tick), 1);
                 chk("ovr29", 32'(overrun), 0);

      // skip=2: triggers at ticks 1, 4, 7
      skip = 4'd2;
      do_reset();
      go_to(10); chk("s2_erase10", 32'(erase_start), 1);
      go_to(20); chk("s2_erase20", 32'(erase_start), 0);
                 chk("s2_busy20", 32'(busy), 0);
      go_to(30); chk("s2_erase30", 32'(erase_start), 0);
      go_to(40); chk("s2_erase40", 32'(erase_start), 1);
      go_to(50); chk("s2_erase50", 32'(erase_start), 0);
      go_to(70); chk("s2_erase70", 32'(erase_start), 1);
      go_to(74); chk("s2_frame74", 32'(frame_num), 2);
      go_to(75); chk("s2_frame75", 32'(frame_num), 3);

      // skip change mid-period only takes effect at the next reload
      skip = 4'd2;
      do_reset();
      go_to(20); skip = 4'd0;
      go_to(30); chk("sc_erase30", 32'(erase_start), 0);
      go_to(40); chk("sc_erase40", 32'(erase_start), 1);
      go_to(50); chk("sc_erase50", 32'(erase_start), 1);

      // Stalled draw: two triggers dropped while busy
      skip = 4'd0; draw_done = 1'b0;
      do_reset();
      go_to(13); chk("st_draw13", 32'(draw_start), 1);
      go_to(20); chk("st_ovr20", 32'(overrun), 1);
                 chk("st_erase20", 32'(erase_start), 0);
      go_to(37); chk("st_busy37", 32'(busy), 1);
                 chk("st_ovr37", 32'(overrun), 2);
                 chk("st_frame37", 32'(frame_num), 0);
      go_to(38); draw_done = 1'b1;
      go_to(39); chk("st_busy39", 32'(busy), 0);
                 chk("st_frame39", 32'(frame_num), 1);
                 chk("st_tick39", 32'(frame_tick), 1);
      go_to(40); chk("st_erase40", 32'(erase_start), 1);
                 chk("st_ovr40", 32'(overrun), 2);

      // draw_done coincident with a trigger: trigger still dropped
      draw_done = 1'b0;
      do_reset();
      go_to(29); draw_done = 1'b1;
      go_to(30); chk("co_busy30", 32'(busy), 0);
                 chk("co_frame30", 32'(frame_num), 1);
                 chk("co_ovr30", 32'(overrun), 2);
                 chk("co_erase30", 32'(erase_start), 0);
      go_to(40); chk("co_erase40", 32'(erase_start), 1);

      // Pause: counter freezes, no ticks; drop run mid-ERASE
      draw_done = 1'b1;
      do_reset();
      go_to(5);  chk("pz_cnt5", 32'(dut.cnt_q), 4);
      run = 1'b0;
      for (int c = 5; c < 25; c++) begin
         go_to(c);
         chk("pz_tick", 32'(frame_tick), 0);
      end
      chk("pz_cnt24", 32'(dut.cnt_q), 4);
      go_to(25); run = 1'b1;
      go_to(28); chk("pz_tick28", 32'(frame_tick), 0);
      go_to(29); chk("pz_tick29", 32'(frame_tick), 1);
      go_to(30); chk("pz_erase30", 32'(erase_start), 1);
      run = 1'b0;
      go_to(32); chk("pz_upd32", 32'(update_en), 1);
      go_to(35); chk("pz_frame35", 32'(frame_num), 1);
                 chk("pz_busy35", 32'(busy), 0);
      go_to(60); chk("pz_frame60", 32'(frame_num), 1);
                 chk("pz_busy60", 32'(busy), 0);
                 chk("pz_cnt60", 32'(dut.cnt_q), 9);

      // Reset while in DRAW
      run = 1'b1; draw_done = 1'b1;
      do_reset();
      go_to(15); draw_done = 1'b0;
      go_to(23); chk("rd_draw23", 32'(draw_start), 1);
      go_to(31); chk("rd_busy31", 32'(busy), 1);
                 chk("rd_frame31", 32'(frame_num), 1);
                 chk("rd_ovr31", 32'(overrun), 1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("rd_busy", 32'(busy), 0);
      chk("rd_pulses", 32'({erase_start, update_en, draw_start}), 0);
      chk("rd_frame", 32'(frame_num), 0);
      chk("rd_ovr", 32'(overrun), 0);
      chk("rd_cnt", 32'(dut.cnt_q), 9);

      // erase_done during the entry ERASE cycle is not looked at
      erase_done = 1'b0; draw_done = 1'b1;
      do_reset();
      go_to(10); chk("fe_erase10", 32'(erase_start), 1);
      erase_done = 1'b1;
      go_to(11); erase_done = 1'b0;
                 chk("fe_upd11", 32'(update_en), 0);
      go_to(12); chk("fe_upd12", 32'(update_en), 0);
                 chk("fe_busy12", 32'(busy), 1);
      erase_done = 1'b1;
      go_to(13); chk("fe_upd13", 32'(update_en), 1);

      // Overrun saturation, then frame_num wrap
      erase_done = 1'b0;
      do_reset();
      go_to(2550); chk("sat_ovr2550", 32'(overrun), 254);
      go_to(2560); chk("sat_ovr2560", 32'(overrun), 255);
      go_to(3010); chk("sat_ovr3010", 32'(overrun), 255);
                   chk("sat_busy3010", 32'(busy), 1);
      force dut.frame_num_q = 16'hFFFF;
      release dut.frame_num_q;
      erase_done = 1'b1;
      go_to(3011); chk("wr_upd3011", 32'(update_en), 1);
      go_to(3013); chk("wr_frame3013", 32'(frame_num), 32'hFFFF);
      go_to(3014); chk("wr_frame3014", 32'(frame_num), 0);
                   chk("wr_busy3014", 32'(busy), 0);
                   chk("wr_ovr3014", 32'(overrun), 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Per-frame scheduler for the game datapath. An internal frame-period counter divides clk into frame ticks. A dynamic frame-skip counter sets game speed. A four-state controller runs one erase -> update -> draw sequence per scheduled frame, handshaking with the VGA erase and draw engines. It sits between the 50 MHz clock domain logic and the object/draw datapath, and reports frame count and overrun statistics.

Parameters:
CYCLES_PER_FRAME, 833333, clk cycles per frame (50 MHz / 60 Hz); must be >= 2
CNT_W, 20, width of period counter; must hold CYCLES_PER_FRAME-1
SKIP_W, 4, width of skip input and skip counter

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
run  input  1  1 = game running; 0 = paused (period counter holds)
skip  input  SKIP_W  frames skipped between updates; update period = skip+1 frames
erase_done  input  1  erase engine finished (one-cycle pulse or level)
draw_done  input  1  draw engine finished (one-cycle pulse or level)
frame_tick  output  1  one-cycle pulse per frame period (combinational from counter)
erase_start  output  1  one-cycle pulse, start erase engine
update_en  output  1  one-cycle pulse, advance game state (positions, collisions)
draw_start  output  1  one-cycle pulse, start draw engine
busy  output  1  1 when FSM not IDLE
frame_num  output  16  completed sequences, wraps at 65535 -> 0
overrun  output  8  dropped triggers, saturates at 255

Behaviour:
- Reset, synchronous on posedge clk when resetn=0: period cnt = CYCLES_PER_FRAME-1; skip_cnt = 0; FSM = IDLE; erase_start/update_en/draw_start = 0; frame_num = 0; overrun = 0. Reset mid-sequence abandons the sequence. No done is awaited afterwards.
- Period counter: when run=1, decrement each cycle. At 0, reload CYCLES_PER_FRAME-1. When run=0, hold.
- frame_tick = run && (cnt == 0). With run held high from reset release, the first tick is in cycle CYCLES_PER_FRAME-1 (0-based), then every CYCLES_PER_FRAME cycles.
- Skip counter: updates on frame_tick only.
  - If skip_cnt == 0: reload with current skip input and raise the internal trigger for that cycle.
  - Otherwise, decrement with no trigger.
  - skip is sampled only at reload. Mid-period changes take effect at the next reload.
  - The first tick after reset triggers.
- FSM states: IDLE, ERASE, UPDATE, DRAW.
  - IDLE: on trigger, go to ERASE next edge.
  - ERASE: erase_start=1 in the first ERASE cycle only. erase_done is sampled from the second ERASE cycle onward. On erase_done, go to UPDATE.
  - UPDATE: exactly one cycle, update_en=1. Then go to DRAW.
  - DRAW: draw_start=1 in the first DRAW cycle only. draw_done is sampled from the second DRAW cycle onward. On draw_done, go to IDLE and increment frame_num on the same edge.
  - erase_start, update_en and draw_start are registered, decoded from state plus a first-cycle flag. They are mutually exclusive.
- Minimum sequence length is 5 cycles (ERASE 2, UPDATE 1, DRAW 2). A trigger in IDLE is never lost.
- Trigger while busy: the trigger is dropped and overrun increments (saturating at 255). The in-flight sequence is unaffected.
- run=0 mid-sequence: the sequence completes normally. No new triggers occur.
- erase_done/draw_done arriving in IDLE, or in the wrong state: ignored.
- Simultaneous draw_done and trigger in the same cycle: the FSM is still DRAW, so the trigger is dropped and counts as overrun.
- Counter wrap: frame_num 65535 -> 0; overrun stays at 255.

Test Plan:
- CYCLES_PER_FRAME=10, skip=0, run=1 from reset, dones tied high: frame_tick in cycles 9, 19, 29. erase_start at 10, update_en at 12, draw_start at 13, frame_num=1 at cycle 15.
- skip=2, dones tied high: triggers at ticks 1, 4, 7 (cycles 9, 39, 69). frame_num=3 after cycle 75. Change skip to 0 at cycle 20: takes effect only after the reload at cycle 39.
- Hold draw_done low for 25 cycles after draw_start: the next two triggers are dropped, overrun=2, busy stays 1. Release draw_done: IDLE, frame_num increments once.
- run=0 at cycle 5 for 20 cycles: cnt freezes at 4 and no tick occurs. With run=1 again, the tick arrives 5 run-cycles later. Then drop run mid-ERASE: the sequence still completes.
- resetn=0 for one cycle while in DRAW: next cycle IDLE, all pulses 0, frame_num=0, overrun=0, cnt=9.
- Force overrun via tied-low erase_done over 300 ticks: overrun saturates at 255. Preload frame_num=65535 via 65535 sequences (or force): next completion wraps it to 0.
